// File: rtl/gray_scale_pkg.sv
`default_nettype none
// ============================================================================
// Module : gray_scale_pkg
// Brief  : Shared types, BT.601 weights, rounding and channel-expansion helpers
// Rev    : 1.0
// ============================================================================
package gray_scale_pkg;

    localparam int GS_DATA_W = 32;
    localparam int GS_IDX_W  = $clog2(GS_DATA_W);

    // BT.601 luma weights in thousandths; scaled to Q0.COEF_BITS by coef_default
    localparam int GS_W_R_MILLI = 299;
    localparam int GS_W_G_MILLI = 587;
    localparam int GS_W_B_MILLI = 114;

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [GS_DATA_W-1:0] data;
    } px_stage_t;

    function automatic logic [GS_DATA_W-1:0] coef_default(input int w_milli, input int coef_bits);
        longint v;
        v = ((longint'(w_milli) << coef_bits) + 64'sd500) / 64'sd1000;
        return GS_DATA_W'(v);
    endfunction

    function automatic logic [GS_DATA_W-1:0] round_const(input int coef_bits);
        return GS_DATA_W'(64'd1 << (coef_bits - 1));
    endfunction

    function automatic logic [GS_DATA_W-1:0] expand_ch(input logic [GS_DATA_W-1:0] c,
                                                        input int ch_bits,
                                                        input int out_bits);
        logic [GS_DATA_W-1:0] e;
        e = '0;
        for (int i = 0; i < GS_DATA_W; i++) begin
            if (i < out_bits) begin
                e[GS_IDX_W'(out_bits - 1 - i)] = c[GS_IDX_W'(ch_bits - 1 - (i % ch_bits))];
            end
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_scale_weight.sv
`default_nettype none
// ============================================================================
// Module : gray_scale_weight
// Brief  : S2 coefficient multiply and S3 sum/round/saturate with stage registers
// Rev    : 1.0
// ============================================================================
module gray_scale_weight
    import gray_scale_pkg::*;
#(
    parameter int OUT_BITS  = 8,
    parameter int COEF_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 adv_i,
    input  logic                 s1_valid_i,
    input  logic                 s1_last_i,
    input  logic [OUT_BITS-1:0]  r_i,
    input  logic [OUT_BITS-1:0]  g_i,
    input  logic [OUT_BITS-1:0]  b_i,
    input  logic [COEF_BITS-1:0] kr_i,
    input  logic [COEF_BITS-1:0] kg_i,
    input  logic [COEF_BITS-1:0] kb_i,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [OUT_BITS-1:0]  gray_o
);

    localparam int PROD_W = OUT_BITS + COEF_BITS;
    localparam int SUM_W  = PROD_W + 2;
    localparam logic [SUM_W-1:0] C_ROUND = SUM_W'(round_const(COEF_BITS));

    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q,  s2_last_d;
    logic [PROD_W-1:0] s2_pr_q, s2_pr_d;
    logic [PROD_W-1:0] s2_pg_q, s2_pg_d;
    logic [PROD_W-1:0] s2_pb_q, s2_pb_d;
    px_stage_t         s3_q, s3_d;

    logic [SUM_W-1:0]    w_sum;
    logic [OUT_BITS+1:0] w_y;
    logic [OUT_BITS-1:0] w_gray;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_pr_d    = s2_pr_q;
        s2_pg_d    = s2_pg_q;
        s2_pb_d    = s2_pb_q;
        if (clear_i) begin
            s2_valid_d = 1'b0;
        end else if (adv_i) begin
            s2_valid_d = s1_valid_i;
            s2_last_d  = s1_last_i;
            s2_pr_d    = PROD_W'(kr_i) * PROD_W'(r_i);
            s2_pg_d    = PROD_W'(kg_i) * PROD_W'(g_i);
            s2_pb_d    = PROD_W'(kb_i) * PROD_W'(b_i);
        end
    end

    // Two guard bits hold three full-scale products plus the rounding half
    assign w_sum  = SUM_W'(s2_pr_q) + SUM_W'(s2_pg_q) + SUM_W'(s2_pb_q) + C_ROUND;
    assign w_y    = (OUT_BITS + 2)'(w_sum >> COEF_BITS);
    assign w_gray = (|w_y[OUT_BITS+1:OUT_BITS]) ? {OUT_BITS{1'b1}} : w_y[OUT_BITS-1:0];

    always_comb begin
        s3_d = s3_q;
        if (clear_i) begin
            s3_d.valid = 1'b0;
        end else if (adv_i) begin
            s3_d.valid = s2_valid_q;
            s3_d.last  = s2_last_q;
            s3_d.data  = GS_DATA_W'(w_gray);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_pr_q    <= '0;
            s2_pg_q    <= '0;
            s2_pb_q    <= '0;
            s3_q       <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_pr_q    <= s2_pr_d;
            s2_pg_q    <= s2_pg_d;
            s2_pb_q    <= s2_pb_d;
            s3_q       <= s3_d;
        end
    end

    assign valid_o = s3_q.valid;
    assign last_o  = s3_q.last;
    assign gray_o  = s3_q.data[OUT_BITS-1:0];

    generate
        if (OUT_BITS < GS_DATA_W) begin : g_data_pad
            logic w_unused_pad;
            assign w_unused_pad = ^s3_q.data[GS_DATA_W-1:OUT_BITS];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gray_scale_pipe.sv
`default_nettype none
// ============================================================================
// Module : gray_scale_pipe
// Brief  : 3-stage valid/ready RGB->luma pipe; GRAY_SCALE_COEF_PROG_EN adds
//          run-time programmable coefficients (cfg_we_i / cfg_coef_i)
// Rev    : 1.0
// ============================================================================
module gray_scale_pipe
    import gray_scale_pkg::*;
#(
    parameter int CH_BITS   = 5,
    parameter int OUT_BITS  = 8,
    parameter int COEF_BITS = 8
) (
`ifdef GRAY_SCALE_COEF_PROG_EN
    input  logic                   cfg_we_i,
    input  logic [3*COEF_BITS-1:0] cfg_coef_i,
`endif
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [3*CH_BITS-1:0]   px_rgb_i,
    input  logic                   last_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [OUT_BITS-1:0]    px_gray_o,
    output logic                   last_o,
    output logic [31:0]            px_count_o
);

    localparam logic [COEF_BITS-1:0] C_KR = COEF_BITS'(coef_default(GS_W_R_MILLI, COEF_BITS));
    localparam logic [COEF_BITS-1:0] C_KG = COEF_BITS'(coef_default(GS_W_G_MILLI, COEF_BITS));
    localparam logic [COEF_BITS-1:0] C_KB = COEF_BITS'(coef_default(GS_W_B_MILLI, COEF_BITS));

    logic                 w_adv;
    logic                 w_xfer;
    logic [OUT_BITS-1:0]  w_r_exp, w_g_exp, w_b_exp;
    logic [COEF_BITS-1:0] w_kr, w_kg, w_kb;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q,  s1_last_d;
    logic [OUT_BITS-1:0] s1_r_q, s1_r_d;
    logic [OUT_BITS-1:0] s1_g_q, s1_g_d;
    logic [OUT_BITS-1:0] s1_b_q, s1_b_d;
    logic [31:0]         px_count_q, px_count_d;

    // One global enable: the whole pipe moves unless the output is held
    assign w_adv   = !valid_o || ready_i;
    assign ready_o = w_adv && !clear_i;
    assign w_xfer  = valid_o && ready_i;

    assign w_r_exp = OUT_BITS'(expand_ch(GS_DATA_W'(px_rgb_i[3*CH_BITS-1:2*CH_BITS]), CH_BITS, OUT_BITS));
    assign w_g_exp = OUT_BITS'(expand_ch(GS_DATA_W'(px_rgb_i[2*CH_BITS-1:CH_BITS]), CH_BITS, OUT_BITS));
    assign w_b_exp = OUT_BITS'(expand_ch(GS_DATA_W'(px_rgb_i[CH_BITS-1:0]), CH_BITS, OUT_BITS));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        if (clear_i) begin
            s1_valid_d = 1'b0;
        end else if (w_adv) begin
            s1_valid_d = valid_i;
            s1_last_d  = last_i;
            s1_r_d     = w_r_exp;
            s1_g_d     = w_g_exp;
            s1_b_d     = w_b_exp;
        end
    end

    assign px_count_d = px_count_q + 32'(w_xfer);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            px_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            px_count_q <= px_count_d;
        end
    end

    assign px_count_o = px_count_q;

`ifdef GRAY_SCALE_COEF_PROG_EN
    // Written value is sampled by S2 from the following edge onward
    logic [3*COEF_BITS-1:0] coef_q, coef_d;

    assign coef_d = cfg_we_i ? cfg_coef_i : coef_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            coef_q <= {C_KR, C_KG, C_KB};
        end else begin
            coef_q <= coef_d;
        end
    end

    assign w_kr = coef_q[3*COEF_BITS-1:2*COEF_BITS];
    assign w_kg = coef_q[2*COEF_BITS-1:COEF_BITS];
    assign w_kb = coef_q[COEF_BITS-1:0];
`else
    assign w_kr = C_KR;
    assign w_kg = C_KG;
    assign w_kb = C_KB;
`endif

    gray_scale_weight #(
        .OUT_BITS  (OUT_BITS),
        .COEF_BITS (COEF_BITS)
    ) u_weight (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .adv_i      (w_adv),
        .s1_valid_i (s1_valid_q),
        .s1_last_i  (s1_last_q),
        .r_i        (s1_r_q),
        .g_i        (s1_g_q),
        .b_i        (s1_b_q),
        .kr_i       (w_kr),
        .kg_i       (w_kg),
        .kb_i       (w_kb),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .gray_o     (px_gray_o)
    );

endmodule
`default_nettype wire
